sample_bram_reader: RTL

//  Read-back end of the sample store. After the random sample generator fills Block RAM,

---
 rtl/sample_bram_reader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sample_bram_reader.sv
// Reads stored X/Y sample pairs back out of Block RAM port B, one pass per start pulse,
// and hands each pair to the consumer over a valid/ready handshake.
module sample_bram_reader #(
   parameter int          NUM_SAMPLES = 100,
   parameter logic [18:0] BASE_ADDR   = 19'h00000,
   parameter int          RD_LAT      = 1
) (
   input  logic        Random1_clk,
   input  logic        Random1_rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        ENB,
   output logic [18:0] ADDRB,
   input  logic [11:0] DOUTB,
   output logic [11:0] sample_x,
   output logic [11:0] sample_y,
   output logic [6:0]  sample_idx,
   output logic        sample_valid,
   input  logic        sample_ready,
   output logic        sample_last
);

   typedef enum logic [2:0] {
      IDLE,
      RD_X,
      WAIT_X,
      RD_Y,
      WAIT_Y,
      PRESENT,
      FIN
   } state_t;

   localparam logic [6:0] LAST_IDX  = 7'(NUM_SAMPLES - 1);
   localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

   state_t      state_reg, state_next;
   logic [6:0]  idx_reg, idx_next;
   logic [6:0]  idx_inc;
   logic [1:0]  wait_reg, wait_next;
   logic [11:0] x_reg, x_next;
   logic [11:0] y_reg, y_next;
   logic [18:0] addr_reg, addr_next;

   assign idx_inc = idx_reg + 7'd1;

   always_ff @(posedge Random1_clk or negedge Random1_rst) begin
      if (!Random1_rst) begin
         state_reg <= IDLE;
         idx_reg   <= 7'd0;
         wait_reg  <= 2'd0;
         x_reg     <= 12'd0;
         y_reg     <= 12'd0;
         addr_reg  <= 19'd0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         wait_reg  <= wait_next;
         x_reg     <= x_next;
         y_reg     <= y_next;
         addr_reg  <= addr_next;
      end
   end

   // The address register is updated on entry to each read state so that it
   // changes together with ENB rising and holds while ENB is low.
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      wait_next  = wait_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      addr_next  = addr_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RD_X;
               idx_next   = 7'd0;
               addr_next  = BASE_ADDR;
            end
         end
         RD_X: begin
            wait_next  = WAIT_LOAD;
            state_next = WAIT_X;
         end
         WAIT_X: begin
            if (wait_reg == 2'd0) begin
               x_next     = DOUTB;
               addr_next  = addr_reg + 19'd1;
               state_next = RD_Y;
            end else begin
               wait_next = wait_reg - 2'd1;
            end
         end
         RD_Y: begin
            wait_next  = WAIT_LOAD;
            state_next = WAIT_Y;
         end
         WAIT_Y: begin
            if (wait_reg == 2'd0) begin
               y_next     = DOUTB;
               state_next = PRESENT;
            end else begin
               wait_next = wait_reg - 2'd1;
            end
         end
         PRESENT: begin
            if (sample_ready) begin
               if (idx_reg == LAST_IDX) begin
                  state_next = FIN;
               end else begin
                  idx_next   = idx_inc;
                  addr_next  = BASE_ADDR + {11'd0, idx_inc, 1'b0};
                  state_next = RD_X;
               end
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign ENB          = (state_reg == RD_X) || (state_reg == RD_Y);
   assign ADDRB        = addr_reg;
   assign busy         = (state_reg != IDLE);
   assign done         = (state_reg == FIN);
   assign sample_valid = (state_reg == PRESENT);
   assign sample_x     = x_reg;
   assign sample_y     = y_reg;
   assign sample_idx   = idx_reg;
   assign sample_last  = sample_valid && (idx_reg == LAST_IDX);

endmodule
